// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack memory-access sequencer.
package hack_pkg;

   localparam int unsigned HACK_ADDR_W      = 15;
   localparam int unsigned HACK_DATA_W      = 16;
   localparam int unsigned HACK_HALF_PERIOD = 19;
   localparam int unsigned HACK_TIMER_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } hack_state_e;

   // CPU request captured at launch and held for the whole access
   typedef struct packed {
      logic [HACK_ADDR_W-1:0] addr;
      logic [HACK_DATA_W-1:0] wdata;
      logic                   we;
   } hack_req_t;

   // Timer reload value for a phase lasting `cycles` clk cycles
   function automatic logic [HACK_TIMER_W-1:0] hack_reload(input int unsigned cycles);
      return HACK_TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/hack_mem_timer.sv
// Loadable down-counter for phase timing; zero is high in the last cycle of a phase.
module hack_mem_timer
   import hack_pkg::*;
#(
   parameter int unsigned W = HACK_TIMER_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         zero  <= 1'b1;
      end else if (load) begin
         count <= load_val;
         zero  <= (load_val == '0);
      end else if (!zero) begin
         count <= count - W'(1);
         zero  <= (count == W'(1));
      end
   end

endmodule

// File: rtl/hack_mem_seq.sv
// Fixed-timing external RAM access sequencer launched by falling-phase strobes.
// Optional RAM wait-state extension enabled by defining HACK_MEM_SEQ_WAIT_EN.
module hack_mem_seq
   import hack_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned ACCESS_CYC = 4,
   parameter int unsigned HOLD_CYC   = 1,
   parameter int unsigned WAIT_MAX   = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   hack_clk,
   input  logic                   strobe,
   input  logic [HACK_ADDR_W-1:0] cpu_addr,
   input  logic [HACK_DATA_W-1:0] cpu_dout,
   input  logic                   cpu_we,
   output logic [HACK_DATA_W-1:0] cpu_din,
   output logic [HACK_ADDR_W-1:0] ram_addr,
   output logic [HACK_DATA_W-1:0] ram_wdata,
   input  logic [HACK_DATA_W-1:0] ram_rdata,
   output logic                   ram_cs_n,
   output logic                   ram_oe_n,
   output logic                   ram_we_n,
   input  logic                   ram_wait,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun
);

`ifdef HACK_MEM_SEQ_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam int unsigned EXT_BUDGET = WAIT_EN ? WAIT_MAX : 0;

   // The whole access, including any wait extension, must fit in one hack_clk half-period
   if (SETUP_CYC < 1 || ACCESS_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase
      $error("hack_mem_seq: SETUP_CYC, ACCESS_CYC and HOLD_CYC must each be at least 1");
   end
   if (SETUP_CYC + ACCESS_CYC + HOLD_CYC + EXT_BUDGET > HACK_HALF_PERIOD - 2) begin : g_bad_total
      $error("hack_mem_seq: access cycle does not fit in the hack_clk half-period");
   end

   hack_state_e              state;
   hack_state_e              next_state;
   hack_req_t                req;
   hack_req_t                req_d;
   logic [HACK_DATA_W-1:0]   cpu_din_d;
   logic                     cs_n_d;
   logic                     oe_n_d;
   logic                     we_n_d;
   logic                     busy_d;
   logic                     done_d;
   logic                     overrun_d;
   logic                     fall_strobe;
   logic                     launch;
   logic                     collide;
   logic                     extend;
   logic                     wait_timeout;
   logic                     timer_load;
   logic [HACK_TIMER_W-1:0]  timer_val;
   logic                     timer_zero;

   assign fall_strobe = strobe & ~hack_clk;
   assign launch      = fall_strobe & (state == ST_IDLE);
   assign collide     = fall_strobe & (state != ST_IDLE);

   assign ram_addr  = req.addr;
   assign ram_wdata = req.wdata;

   hack_mem_timer #(
      .W (HACK_TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

`ifdef HACK_MEM_SEQ_WAIT_EN
   localparam int unsigned EXT_W = $clog2(WAIT_MAX + 2);
   logic [EXT_W-1:0] ext_cnt;

   // Counts wait-state extensions of the current access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_cnt <= '0;
      end else if (launch) begin
         ext_cnt <= '0;
      end else if (extend) begin
         ext_cnt <= ext_cnt + EXT_W'(1);
      end
   end
`else
   logic unused_wait;
   assign unused_wait = ram_wait;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         req      <= '0;
         cpu_din  <= '0;
         ram_cs_n <= 1'b1;
         ram_oe_n <= 1'b1;
         ram_we_n <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= next_state;
         req      <= req_d;
         cpu_din  <= cpu_din_d;
         ram_cs_n <= cs_n_d;
         ram_oe_n <= oe_n_d;
         ram_we_n <= we_n_d;
         busy     <= busy_d;
         done     <= done_d;
         overrun  <= overrun_d;
      end
   end

   // Next-state logic
   always_comb begin
      next_state   = state;
      extend       = 1'b0;
      wait_timeout = 1'b0;
      unique case (state)
         ST_IDLE:   if (launch)     next_state = ST_SETUP;
         ST_SETUP:  if (timer_zero) next_state = ST_ACCESS;
         ST_ACCESS: begin
            if (timer_zero) begin
`ifdef HACK_MEM_SEQ_WAIT_EN
               if (ram_wait && (ext_cnt < EXT_W'(WAIT_MAX))) begin
                  extend = 1'b1;
               end else begin
                  next_state   = ST_HOLD;
                  wait_timeout = ram_wait;
               end
`else
               next_state = ST_HOLD;
`endif
            end
         end
         ST_HOLD:   if (timer_zero) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and timer control
   always_comb begin
      req_d      = req;
      cpu_din_d  = cpu_din;
      timer_load = 1'b0;
      timer_val  = '0;

      if (launch) begin
         req_d.addr  = cpu_addr;
         req_d.wdata = cpu_dout;
         req_d.we    = cpu_we;
      end

      cs_n_d    = (next_state == ST_IDLE);
      oe_n_d    = ~(~req_d.we & ((next_state == ST_SETUP) | (next_state == ST_ACCESS)));
      we_n_d    = ~(req_d.we & (next_state == ST_ACCESS));
      busy_d    = (next_state != ST_IDLE);
      done_d    = (state == ST_HOLD) && (next_state == ST_IDLE);
      overrun_d = overrun | collide | wait_timeout;

      // Read data is taken on the edge that closes the (possibly extended) access window
      if ((state == ST_ACCESS) && (next_state == ST_HOLD) && !req.we) begin
         cpu_din_d = ram_rdata;
      end

      if (extend) begin
         timer_load = 1'b1;
         timer_val  = '0;
      end else if ((next_state != state) && (next_state != ST_IDLE)) begin
         timer_load = 1'b1;
         unique case (next_state)
            ST_SETUP:  timer_val = hack_reload(SETUP_CYC);
            ST_ACCESS: timer_val = hack_reload(ACCESS_CYC);
            ST_HOLD:   timer_val = hack_reload(HOLD_CYC);
            default:   timer_val = '0;
         endcase
      end
   end

endmodule
